regfile_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the 16x16 register file and ALU. Accepts one 16-bit instruction per valid/ready

---
 rtl/regfile_ctrl_pkg.sv | 24 ++
 rtl/regfile_instr_decode.sv | 42 ++++
 rtl/regfile_seq_ctrl.sv | 97 +++++++++
 tb/tb_regfile_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file sequencer.
// State encoding, instruction field positions and default compare code.
package regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int EXT_MSB = 7;
    localparam int EXT_LSB = 4;
    localparam int RS_MSB  = 3;
    localparam int RS_LSB  = 0;

    localparam logic [3:0] OP_REG       = 4'b0000;
    localparam logic [3:0] CMP_FUNC_DEF = 4'b1011;

endpackage

// File: rtl/regfile_instr_decode.sv
// Combinational decode of the latched instruction into ALU and
// register-file controls, plus the no-writeback flag.
module regfile_instr_decode
    import regfile_ctrl_pkg::*;
#(
    parameter logic [3:0] CMP_FUNC    = CMP_FUNC_DEF,
    parameter bit         ZERO_REG_RO = 1'b0
) (
    input  logic [15:0] instr,
    output logic [3:0]  alu_func,
    output logic        imm_sel,
    output logic [15:0] imm,
    output logic [3:0]  rdest,
    output logic [3:0]  rsrc,
    output logic        no_wb
);

    logic [3:0] op;

    always_comb begin
        op       = instr[OP_MSB:OP_LSB];
        rdest    = instr[RD_MSB:RD_LSB];
        rsrc     = instr[RS_MSB:RS_LSB];
        alu_func = 4'h0;
        imm_sel  = 1'b0;
        imm      = 16'h0000;
        unique case (1'b1)
            (op == OP_REG): begin
                alu_func = instr[EXT_MSB:EXT_LSB];
            end
            default: begin
                alu_func = op;
                imm_sel  = 1'b1;
                imm      = {{8{instr[EXT_MSB]}}, instr[EXT_MSB:RS_LSB]};
            end
        endcase
        // R0 protection only applies when the parameter enables it
        no_wb = (alu_func == CMP_FUNC) ||
                (ZERO_REG_RO && (rdest == 4'd0));
    end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle sequencer: accepts one instruction, then walks
// READ -> EXEC -> WB to drive the register file and ALU.
module regfile_seq_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter logic [3:0] CMP_FUNC    = CMP_FUNC_DEF,
    parameter bit         ZERO_REG_RO = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Instr_Valid,
    output logic        Instr_Ready,
    input  logic [15:0] Instr,
    input  logic        Hold,
    output logic [3:0]  Reg_Read_A,
    output logic [3:0]  Reg_Read_B,
    output logic [3:0]  Reg_Write,
    output logic        Write_Enable,
    output logic [3:0]  ALU_Func,
    output logic        Imm_Sel,
    output logic [15:0] Imm,
    output logic        Busy,
    output logic        Done
);

    state_t      state, next_state;
    logic [15:0] instr_q;
    logic [3:0]  rdest, rsrc;
    logic        no_wb;
    logic        accept;

    regfile_instr_decode #(
        .CMP_FUNC    (CMP_FUNC),
        .ZERO_REG_RO (ZERO_REG_RO)
    ) u_decode (
        .instr    (instr_q),
        .alu_func (ALU_Func),
        .imm_sel  (Imm_Sel),
        .imm      (Imm),
        .rdest    (rdest),
        .rsrc     (rsrc),
        .no_wb    (no_wb)
    );

    assign accept = (state == IDLE) && Instr_Valid && !Hold;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            instr_q <= 16'h0000;
        end else begin
            state <= next_state;
            if (accept) begin
                instr_q <= Instr;
            end
        end
    end

    always_comb begin
        next_state   = state;
        Instr_Ready  = 1'b0;
        Write_Enable = 1'b0;
        Done         = 1'b0;
        // Hold freezes the state and masks every strobe
        if (!Hold) begin
            unique case (state)
                IDLE: begin
                    Instr_Ready = 1'b1;
                    if (Instr_Valid) begin
                        next_state = READ;
                    end
                end
                READ: next_state = EXEC;
                EXEC: begin
                    if (no_wb) begin
                        Done       = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = WB;
                    end
                end
                WB: begin
                    Write_Enable = 1'b1;
                    Done         = 1'b1;
                    next_state   = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign Reg_Read_A = rdest;
    assign Reg_Read_B = rsrc;
    assign Reg_Write  = rdest;
    assign Busy       = ~Instr_Ready;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl: default instance plus an
// instance with R0 made read-only, both driven by the same stimulus.
module tb_regfile_seq_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Instr_Valid;
    logic [15:0] Instr;
    logic        Hold;

    logic        rdy, we, imm_sel, busy, done;
    logic [3:0]  rra, rrb, rwr, func;
    logic [15:0] imm;

    logic        rdy2, we2, imm_sel2, busy2, done2;
    logic [3:0]  rra2, rrb2, rwr2, func2;
    logic [15:0] imm2;

    int n_chk  = 0;
    int n_pass = 0;
    int we_cnt = 0;

    always #5 Clk = ~Clk;

    regfile_seq_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Instr_Valid  (Instr_Valid),
        .Instr_Ready  (rdy),
        .Instr        (Instr),
        .Hold         (Hold),
        .Reg_Read_A   (rra),
        .Reg_Read_B   (rrb),
        .Reg_Write    (rwr),
        .Write_Enable (we),
        .ALU_Func     (func),
        .Imm_Sel      (imm_sel),
        .Imm          (imm),
        .Busy         (busy),
        .Done         (done)
    );

    regfile_seq_ctrl #(.ZERO_REG_RO(1'b1)) dut_ro (
        .Clk          (Clk),
        .Reset        (Reset),
        .Instr_Valid  (Instr_Valid),
        .Instr_Ready  (rdy2),
        .Instr        (Instr),
        .Hold         (Hold),
        .Reg_Read_A   (rra2),
        .Reg_Read_B   (rrb2),
        .Reg_Write    (rwr2),
        .Write_Enable (we2),
        .ALU_Func     (func2),
        .Imm_Sel      (imm_sel2),
        .Imm          (imm2),
        .Busy         (busy2),
        .Done         (done2)
    );

    always @(posedge Clk) begin
        if (we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [9:0] acc;
        int         we_before;

        Reset       = 1'b1;
        Instr_Valid = 1'b0;
        Instr       = 16'h0000;
        Hold        = 1'b0;
        #1;
        check("rst_ready", rdy, 1);
        check("rst_we", we, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rra", rra, 0);
        check("rst_imm", {imm_sel, imm}, 0);
        tick();
        tick();
        Reset = 1'b0;

        // reg form 0353: R3 <- R3 f5 R3
        Instr       = 16'h0353;
        Instr_Valid = 1'b1;
        check("t2_ready", rdy, 1);
        tick();
        Instr_Valid = 1'b0;
        Instr       = 16'hFFFF;
        check("t2_read_a", rra, 3);
        check("t2_read_b", rrb, 3);
        check("t2_busy", {busy, rdy, we}, 3'b100);
        tick();
        check("t2_func", func, 5);
        check("t2_immsel", imm_sel, 0);
        check("t2_exec_strb", {we, done}, 2'b00);
        tick();
        check("t2_wb_strb", {we, done}, 2'b11);
        check("t2_wr_addr", rwr, 3);
        tick();
        check("t2_idle", {rdy, we, done}, 3'b100);

        // imm form 52FF: R2 <- R2 f5 sext(FF)
        Instr       = 16'h52FF;
        Instr_Valid = 1'b1;
        tick();
        Instr_Valid = 1'b0;
        check("t3_read_a", rra, 2);
        tick();
        check("t3_func", func, 5);
        check("t3_immsel", imm_sel, 1);
        check("t3_imm", imm, 16'hFFFF);
        check("t3_exec_strb", {we, done}, 2'b00);
        tick();
        check("t3_wb", {we, done, rwr}, {2'b11, 4'd2});
        tick();

        // compare 01B4: retires from EXEC without writeback
        Instr       = 16'h01B4;
        Instr_Valid = 1'b1;
        we_before   = we_cnt;
        tick();
        Instr_Valid = 1'b0;
        check("t4_read", {rra, rrb}, 8'h14);
        tick();
        check("t4_done", {we, done}, 2'b01);
        check("t4_func", func, 4'hB);
        tick();
        check("t4_ready", {rdy, we, done}, 3'b100);
        check("t4_no_we", we_cnt - we_before, 0);

        // hold in EXEC for 5 cycles, then in WB once
        Instr       = 16'h0712;
        Instr_Valid = 1'b1;
        we_before   = we_cnt;
        tick();
        Instr_Valid = 1'b0;
        tick();
        Hold = 1'b1;
        #1;
        check("t5_hold_rdy", rdy, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_strb", {we, done}, 2'b00);
        end
        check("t5_hold_func", func, 1);
        Hold = 1'b0;
        #1;
        check("t5_exec_strb", {we, done}, 2'b00);
        tick();
        check("t5_wb", {we, done, rwr}, {2'b11, 4'd7});
        Hold = 1'b1;
        #1;
        check("t5_wb_held", {we, done}, 2'b00);
        tick();
        check("t5_wb_held2", {we, done, rdy}, 3'b000);
        Hold = 1'b0;
        #1;
        check("t5_wb_again", {we, done}, 2'b11);
        tick();
        check("t5_idle", {rdy, we}, 2'b10);
        check("t5_we_once", we_cnt - we_before, 1);

        // Valid held 10 cycles: accepts only every 4th cycle
        Instr = 16'h0353;
        for (int i = 0; i < 10; i++) begin
            Instr_Valid = 1'b1;
            #1;
            acc[i] = rdy;
            tick();
        end
        Instr_Valid = 1'b0;
        check("t6_accepts", acc, 10'h111);
        tick();
        tick();
        check("t6_drain", {rdy, rdy2}, 2'b11);

        // R0 write: default instance writes, read-only instance does not
        Instr       = 16'h1005;
        Instr_Valid = 1'b1;
        tick();
        Instr_Valid = 1'b0;
        tick();
        check("t6_ro_exec", {we2, done2}, 2'b01);
        check("t6_rw_exec", {we, done}, 2'b00);
        tick();
        check("t6_rw_wb", {we, done, rwr}, {2'b11, 4'd0});
        check("t6_ro_idle", {rdy2, we2, done2}, 3'b100);
        tick();

        // reset asserted while in WB aborts the write
        Instr       = 16'h52FF;
        Instr_Valid = 1'b1;
        tick();
        Instr_Valid = 1'b0;
        tick();
        tick();
        check("t1_in_wb", we, 1);
        Reset = 1'b1;
        #1;
        check("t1_rst_we", {we, done}, 2'b00);
        check("t1_rst_rdy", rdy, 1);
        check("t1_rst_regs", {rra, rrb, rwr, func}, 0);
        check("t1_rst_imm", {imm_sel, imm}, 0);
        Reset = 1'b0;
        tick();
        check("t1_after", {rdy, we, done}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
